// File: rtl/trap_ctrl.sv
// Trap sequencer: takes exceptions, mret and enabled interrupts at commit, pulses csr
// for one cycle, then flushes and redirects fetch under a ready/valid handshake.
package trap_ctrl_pkg;
  typedef enum logic [2:0] {
    ITYPE_NONE      = 3'd0,
    ITYPE_EXCEPTION = 3'd1,
    ITYPE_TIMER     = 3'd2,
    ITYPE_SOFTWARE  = 3'd3,
    ITYPE_EXTERNAL  = 3'd4
  } interrupt_type;
endpackage

module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int unsigned EXT_SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          commit_valid,
  output logic          commit_ready,
  input  logic [63:0]   commit_pc,
  input  logic          commit_exc,
  input  logic [62:0]   commit_exc_code,
  input  logic          commit_mret,
  input  logic          timer_irq,
  input  logic          sw_irq,
  input  logic          ext_irq,
  input  logic          csr_mie,
  input  logic [63:0]   csr_mtvec,
  input  logic [63:0]   csr_mepc,
  output logic          csr_enter,
  output logic          csr_leave,
  output logic [63:0]   csr_pc,
  output logic [62:0]   csr_code,
  output interrupt_type csr_itype,
  output logic          flush,
  output logic          redirect_valid,
  input  logic          redirect_ready,
  output logic [63:0]   redirect_pc
);

  typedef enum logic [1:0] {IDLE, UPDATE, REDIRECT} state_t;

  state_t        state_q, state_d;
  interrupt_type kind_q, kind_d;
  logic          mret_q, mret_d;
  logic [62:0]   code_q, code_d;
  logic [63:0]   pc_q, pc_d;
  logic [63:0]   rpc_q, rpc_d;
  logic [EXT_SYNC_STAGES-1:0] sync_q;
  logic          ext_sync;
  logic [63:0]   vec_base;

  assign ext_sync = sync_q[EXT_SYNC_STAGES-1];
  assign vec_base = {csr_mtvec[63:2], 2'b00};

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    mret_d  = mret_q;
    code_d  = code_q;
    pc_d    = pc_q;
    rpc_d   = rpc_q;
    case (state_q)
      IDLE: begin
        if (commit_valid) begin
          pc_d = commit_pc;
          if (commit_exc) begin
            state_d = UPDATE;
            kind_d  = ITYPE_EXCEPTION;
            mret_d  = 1'b0;
            code_d  = commit_exc_code;
          end else if (commit_mret) begin
            state_d = UPDATE;
            kind_d  = ITYPE_NONE;
            mret_d  = 1'b1;
            code_d  = '0;
          end else if (csr_mie && ext_sync) begin
            state_d = UPDATE;
            kind_d  = ITYPE_EXTERNAL;
            mret_d  = 1'b0;
            code_d  = 63'd11;
          end else if (csr_mie && sw_irq) begin
            state_d = UPDATE;
            kind_d  = ITYPE_SOFTWARE;
            mret_d  = 1'b0;
            code_d  = 63'd3;
          end else if (csr_mie && timer_irq) begin
            state_d = UPDATE;
            kind_d  = ITYPE_TIMER;
            mret_d  = 1'b0;
            code_d  = 63'd7;
          end else begin
            pc_d = pc_q;
          end
        end
      end
      UPDATE: begin
        // Target is captured here so it reflects csr state at REDIRECT entry and then holds.
        state_d = REDIRECT;
        if (mret_q) begin
          rpc_d = csr_mepc;
        end else if (kind_q == ITYPE_EXCEPTION || csr_mtvec[1:0] != 2'b01) begin
          rpc_d = vec_base;
        end else begin
          rpc_d = vec_base + {code_q[61:0], 2'b00};
        end
      end
      REDIRECT: begin
        if (redirect_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      kind_q  <= ITYPE_NONE;
      mret_q  <= 1'b0;
      code_q  <= '0;
      pc_q    <= '0;
      rpc_q   <= '0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      mret_q  <= mret_d;
      code_q  <= code_d;
      pc_q    <= pc_d;
      rpc_q   <= rpc_d;
      sync_q  <= {sync_q[EXT_SYNC_STAGES-2:0], ext_irq};
    end
  end

  assign commit_ready   = (state_q == IDLE);
  assign csr_enter      = (state_q == UPDATE) && !mret_q;
  assign csr_leave      = (state_q == UPDATE) && mret_q;
  assign csr_itype      = (state_q == UPDATE) ? kind_q : ITYPE_NONE;
  assign csr_pc         = pc_q;
  assign csr_code       = code_q;
  assign flush          = (state_q != IDLE);
  assign redirect_valid = (state_q == REDIRECT);
  assign redirect_pc    = rpc_q;

endmodule
